// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl -- test-pattern frame controller between a sync generator
// and an HDMI transmitter.
//
// A host configuration request (pattern + solid colour) is captured into
// shadow registers and applied only at the next frame boundary, so a frame is
// never drawn with a mix of old and new settings. Pixel colour comes from one
// of four patterns; timing and colour leave through a fixed 2-stage pipeline.
//
// Optional feature: define VGA_FRAME_CTRL_AUTOCYCLE_EN to advance the active
// pattern (mod 4) every AUTO_FRAMES frame boundaries while no request is in
// flight. Without the macro the pattern changes only through cfg requests.
//
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   cfg_valid/cfg_ready         request handshake (ready only in IDLE)
//   cfg_pattern, cfg_color      0 solid, 1 bars, 2 checker, 3 gradient; {R,G,B}
//   hsync, vsync, vde, px, py   timing and coordinates from the sync generator
//   hsync_o, vsync_o, vde_o     timing delayed by 2 cycles
//   red, green, blue            pixel colour, 0 outside the active area
//   frame_cnt                   frame boundaries seen (wraps)
//   busy                        request pending or being applied
module vga_frame_ctrl #(
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned AUTO_FRAMES     = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_pattern,
  input  logic [23:0] cfg_color,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        vde,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        vde_o,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  // Raw level of a deasserted sync line.
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_e;

  state_e      state_q;
  logic        cfg_ready_q, busy_q;
  logic [1:0]  shd_pat_q, act_pat_q;
  logic [23:0] shd_col_q, act_col_q;
  logic [15:0] frame_cnt_q;
  logic        vs_prev_q;
`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
  logic [15:0] auto_cnt_q;
`endif

  // Frame boundary: first cycle of an asserted vsync.
  logic vs_asrt, boundary, accept;
  assign vs_asrt  = SYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign boundary = vs_asrt & ~vs_prev_q;
  assign accept   = cfg_valid & cfg_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      vs_prev_q   <= vs_asrt;
      if (boundary) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Request FSM. Active pattern/colour are owned here (auto-cycle included)
  // so there is a single writer for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      shd_pat_q   <= 2'd0;
      shd_col_q   <= 24'h0;
      act_pat_q   <= 2'd0;
      act_col_q   <= 24'h0;
`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
      auto_cnt_q  <= 16'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // A request taken on a boundary cycle waits for the next one,
            // and pre-empts any auto step due on this boundary.
            state_q     <= PENDING;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            shd_pat_q   <= cfg_pattern;
            shd_col_q   <= cfg_color;
          end else begin
            cfg_ready_q <= 1'b1;
`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
            if (boundary) begin
              if (auto_cnt_q == 16'(AUTO_FRAMES - 1)) begin
                act_pat_q  <= act_pat_q + 2'd1;
                auto_cnt_q <= 16'd0;
              end else begin
                auto_cnt_q <= auto_cnt_q + 16'd1;
              end
            end
`endif
          end
        end
        PENDING: begin
          if (boundary) state_q <= APPLY;
        end
        APPLY: begin
          act_pat_q   <= shd_pat_q;
          act_col_q   <= shd_col_q;
          state_q     <= IDLE;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
          auto_cnt_q  <= 16'd0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pattern generator (stage 1 input).
  logic [9:0]  bar_div;
  logic [2:0]  bar;
  logic [23:0] pix_rgb;
  always_comb begin
    bar_div = px / 10'd80;
    bar     = (bar_div > 10'd7) ? 3'd7 : bar_div[2:0];
    pix_rgb = act_col_q;
    case (act_pat_q)
      2'd0: pix_rgb = act_col_q;
      // Bars white,yellow,cyan,green,magenta,red,blue,black: each channel is
      // on exactly when one bit of the bar index is clear.
      2'd1: pix_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      2'd2: pix_rgb = (px[5] ^ py[5]) ? 24'hFFFFFF : act_col_q;
      2'd3: pix_rgb = {px[9:2], py[8:1], 8'h00};
      default: pix_rgb = act_col_q;
    endcase
  end

  logic unused_py;
  assign unused_py = py[9] ^ py[0];

  // Two-stage pixel pipeline.
  logic        s1_hs_q, s1_vs_q, s1_de_q;
  logic [23:0] s1_rgb_q;
  logic        s2_hs_q, s2_vs_q, s2_de_q;
  logic [23:0] s2_rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs_q  <= SYNC_OFF;
      s1_vs_q  <= SYNC_OFF;
      s1_de_q  <= 1'b0;
      s1_rgb_q <= 24'h0;
      s2_hs_q  <= SYNC_OFF;
      s2_vs_q  <= SYNC_OFF;
      s2_de_q  <= 1'b0;
      s2_rgb_q <= 24'h0;
    end else begin
      s1_hs_q  <= hsync;
      s1_vs_q  <= vsync;
      s1_de_q  <= vde;
      s1_rgb_q <= pix_rgb;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s2_de_q  <= s1_de_q;
      s2_rgb_q <= s1_de_q ? s1_rgb_q : 24'h0;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign hsync_o   = s2_hs_q;
  assign vsync_o   = s2_vs_q;
  assign vde_o     = s2_de_q;
  assign red       = s2_rgb_q[23:16];
  assign green     = s2_rgb_q[15:8];
  assign blue      = s2_rgb_q[7:0];

endmodule

// File: doc/vga_frame_ctrl.md
VGA_FRAME_CTRL -- requirements
Module: vga_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning hsync/vsync inputs and outputs are active-low when 1 and active-high when 0.
REQ-002 SHALL have parameter AUTO_FRAMES, default 60, meaning the frames per pattern step in auto-cycle mode (legal range 1..65535).
REQ-003 SHALL have port clk, input, 1 bit: the pixel clock, on which all logic is clocked, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid, input, 1 bit: a configuration request is offered.
REQ-006 SHALL have port cfg_ready, output, 1 bit: the controller can accept a request.
REQ-007 SHALL have port cfg_pattern, input, 2 bits: pattern select (0 solid, 1 colour bars, 2 checkerboard, 3 gradient).
REQ-008 SHALL have port cfg_color, input, 24 bits: solid colour {R,G,B}.
REQ-009 SHALL have ports hsync, vsync and vde, inputs, 1 bit each: timing from the sync generator.
REQ-010 SHALL have ports px and py, inputs, 10 bits each: pixel coordinates from the sync generator.
REQ-011 SHALL have ports hsync_o, vsync_o and vde_o, outputs, 1 bit each: delayed timing to the HDMI transmitter.
REQ-012 SHALL have ports red, green and blue, outputs, 8 bits each: pixel colour.
REQ-013 SHALL have port frame_cnt, output, 16 bits: the count of frame boundaries seen.
REQ-014 SHALL have port busy, output, 1 bit: a request is pending or being applied.

Function
REQ-015 Frame boundary SHALL be the first cycle vsync is asserted, per SYNC_ACTIVE_LOW (asserted now, deasserted on the previous cycle).
REQ-016 The FSM SHALL have three states: IDLE, PENDING and APPLY.
- IDLE -> PENDING on cfg_valid && cfg_ready.
- PENDING -> APPLY on a frame boundary.
- APPLY -> IDLE after exactly 1 cycle.
REQ-017 cfg_ready SHALL be 1 only in IDLE; the request is accepted on cfg_valid && cfg_ready; cfg_pattern and cfg_color SHALL be captured into shadow registers on acceptance.
REQ-018 In APPLY, the active pattern and colour SHALL be loaded from the shadow registers; the new values take effect from the first pixel after that boundary.
REQ-019 busy SHALL be 1 in PENDING and APPLY, and 0 in IDLE.
REQ-020 A request accepted in the same cycle as a frame boundary SHALL NOT use that boundary; it is applied at the next one.
REQ-021 The pixel pipeline SHALL have a fixed 2-cycle latency: hsync_o, vsync_o, vde_o and the colour outputs equal the values derived from the inputs two cycles earlier.
REQ-022 When delayed vde is 0, red, green and blue SHALL be 0.
REQ-023 Pattern 0 (solid) SHALL output the active colour.
REQ-024 Pattern 1 (colour bars) SHALL use bar index = px/80, clamped to 7; bars 0..7 SHALL be white, yellow, cyan, green, magenta, red, blue, black, each channel 8'hFF or 8'h00.
REQ-025 Pattern 2 (checkerboard) SHALL output white when px[5]^py[5] is 1, and the active colour otherwise.
REQ-026 Pattern 3 (gradient) SHALL output red = px[9:2], green = py[8:1], blue = 8'h00.
REQ-027 frame_cnt SHALL increment by 1 on every frame boundary and wrap from 16'hFFFF to 0.
REQ-028 Coordinate and colour arithmetic SHALL be unsigned; no output value may exceed 8 bits (truncate, never saturate).

Reset
REQ-029 While rst is 1, the following SHALL be driven:
- FSM = IDLE, cfg_ready = 0, busy = 0.
- Active pattern = 0, active colour = 24'h000000, shadow registers cleared.
- frame_cnt = 0, auto counter = 0.
- Pipeline flushed: red, green and blue = 0, vde_o = 0, and hsync_o and vsync_o at their deasserted level.
REQ-030 cfg_ready SHALL be 1 on the first cycle after rst falls.
REQ-031 A reset asserted while PENDING or APPLY SHALL discard the pending request; it is never applied.

Configuration
REQ-032 Macro VGA_FRAME_CTRL_AUTOCYCLE_EN, when defined, SHALL count frame boundaries; after AUTO_FRAMES boundaries with the FSM in IDLE, the active pattern increments modulo 4 and the counter clears.
REQ-033 With the macro defined, an APPLY SHALL clear the auto counter, and a host request SHALL take precedence over an auto step on the same boundary.
REQ-034 Without the macro, the auto-cycle logic SHALL be absent; the pattern changes only via a cfg request, and ports and latency are unchanged.

Verification
REQ-035 The bench SHALL drive reset, then cfg_valid = 1 with pattern 0 and colour 24'h123456 mid-frame, and check:
- cfg_ready drops the next cycle.
- busy = 1 until the boundary.
- Output stays the old colour until the first vde pixel after the boundary, then becomes 8'h12/8'h34/8'h56.
REQ-036 The bench SHALL offer a request in the exact boundary cycle, and check the pattern is applied one full frame later and frame_cnt has advanced by 2.
REQ-037 The bench SHALL select pattern 1 and check px = 79 gives white, px = 80 gives yellow and px = 639 gives black, each with exactly 2-cycle latency relative to vde.
REQ-038 The bench SHALL assert rst while PENDING, and check that after release the pattern = 0, the colour = 0, busy = 0, and cfg_ready = 1 on the next cycle.
REQ-039 The bench SHALL preload frame_cnt to 16'hFFFF by running boundaries, and check it wraps to 0 on the next boundary.
REQ-040 With VGA_FRAME_CTRL_AUTOCYCLE_EN defined and AUTO_FRAMES = 2, the bench SHALL run with no requests and check the pattern sequence 0,1,2,3,0 changes every 2 frames.
